// File: rtl/dummy.sv
// -----------------------------------------------------------------------------
// dummy -- registered frame processor with eCPRI MAC swap.
//
// Each accepted frame is classified combinationally on its EtherType and the
// eCPRI revision nibble. eCPRI frames have their destination and source MAC
// addresses swapped, so the reply goes back to the sender. All other frames
// pass through unchanged. The whole frame is registered, so there is no
// combinational path from inp to out.
//
// Optional feature: define DUMMY_STATS_EN to add the 32-bit pkt_cnt and
// ecpri_cnt frame counters. Both clear on rst and wrap at 2^32.
// -----------------------------------------------------------------------------
module dummy #(
  parameter int          PKT_BYTES = 64,       // frame buffer depth in bytes (>= 15)
  parameter logic [15:0] ETYPE     = 16'hAEFE  // EtherType that marks eCPRI
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  inp [PKT_BYTES],
  input  logic        inp_en,
  output logic [7:0]  out [PKT_BYTES],
  output logic        out_en,
  output logic        out_ecpri
`ifdef DUMMY_STATS_EN
  ,
  output logic [31:0] pkt_cnt,
  output logic [31:0] ecpri_cnt
`endif
);

  localparam int MAC_BYTES = 6;

  logic       is_ecpri;
  logic [7:0] frame_q [PKT_BYTES];
  logic [7:0] frame_d [PKT_BYTES];
  logic       en_q;
  logic       ecpri_q;
  logic       ecpri_d;

  // Classify the incoming frame: EtherType bytes 12/13 plus revision nibble 1.
  assign is_ecpri = (inp[12] == ETYPE[15:8]) &&
                    (inp[13] == ETYPE[7:0])  &&
                    (inp[14][7:4] == 4'h1);

  // Next-state frame: hold when idle, otherwise load with an optional MAC swap.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // it unassigned and no latch can be inferred.
    frame_d = frame_q;
    ecpri_d = ecpri_q;
    if (inp_en) begin
      for (int i = 0; i < PKT_BYTES; i++) begin
        frame_d[i] = inp[i];
      end
      if (is_ecpri) begin
        // Swap the destination MAC (bytes 0..5) and the source MAC (bytes 6..11).
        // Bytes 12 and above, which include the eCPRI header, are never touched.
        for (int i = 0; i < MAC_BYTES; i++) begin
          frame_d[i]             = inp[i + MAC_BYTES];
          frame_d[i + MAC_BYTES] = inp[i];
        end
      end
      ecpri_d = is_ecpri;
    end
  end

  // Frame, valid and class registers. Reset takes priority over a new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the frame buffer is cleared on reset because out must read as
      // all-zero after reset. It is a flop array, not a RAM, so this is legal.
      for (int i = 0; i < PKT_BYTES; i++) begin
        frame_q[i] <= 8'h00;
      end
      en_q    <= 1'b0;
      ecpri_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      frame_q <= frame_d;
      en_q    <= inp_en;
      ecpri_q <= ecpri_d;
    end
  end

  assign out       = frame_q;
  assign out_en    = en_q;
  assign out_ecpri = ecpri_q;

`ifdef DUMMY_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [31:0] ecpri_cnt_q;

  // Count accepted frames and accepted eCPRI frames. Both wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q   <= 32'd0;
      ecpri_cnt_q <= 32'd0;
    end else if (inp_en) begin
      pkt_cnt_q <= pkt_cnt_q + 32'd1;
      if (is_ecpri) begin
        ecpri_cnt_q <= ecpri_cnt_q + 32'd1;
      end
    end
  end

  assign pkt_cnt   = pkt_cnt_q;
  assign ecpri_cnt = ecpri_cnt_q;
`endif

endmodule

// File: tb/tb_dummy.sv
// -----------------------------------------------------------------------------
// tb_dummy -- table-driven bench for dummy, plus hand-written sequences for
// reset, the reference eCPRI frame, loopback hold/swap-back, mid-stream reset
// and (with DUMMY_STATS_EN) the frame counters.
// -----------------------------------------------------------------------------
module tb_dummy;

  localparam int          N  = 64;
  localparam logic [15:0] ET = 16'hAEFE;

  logic       clk = 1'b0;
  logic       rst;
  logic       inp_en;
  logic       loopback;
  logic [7:0] stim      [N];
  logic [7:0] inp       [N];
  logic [7:0] out       [N];
  logic [7:0] exp_frame [N];
  logic       out_en;
  logic       out_ecpri;
`ifdef DUMMY_STATS_EN
  logic [31:0] pkt_cnt;
  logic [31:0] ecpri_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // In loopback mode the DUT output is fed straight back to its input.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      inp[i] = loopback ? out[i] : stim[i];
    end
  end

  dummy #(.PKT_BYTES(N), .ETYPE(ET)) dut (
    .clk       (clk),
    .rst       (rst),
    .inp       (inp),
    .inp_en    (inp_en),
    .out       (out),
    .out_en    (out_en),
    .out_ecpri (out_ecpri)
`ifdef DUMMY_STATS_EN
    ,
    .pkt_cnt   (pkt_cnt),
    .ecpri_cnt (ecpri_cnt)
`endif
  );

  typedef struct packed {
    logic [7:0]  seed;       // byte i of the frame = seed + i
    logic [15:0] et;         // bytes 12..13
    logic [7:0]  b14;        // byte 14 (eCPRI revision in the upper nibble)
    logic        en;         // inp_en this cycle; out_en expected next cycle
    logic        swap;       // expected MAC swap when loaded
    logic        exp_ecpri;  // expected out_ecpri after the edge
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_frame(input string name);
    int bad;
    bad = -1;
    checks++;
    for (int i = 0; i < N; i++) begin
      if (bad < 0 && out[i] !== exp_frame[i]) bad = i;
    end
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: byte %0d got %02h expected %02h", name, bad, out[bad], exp_frame[bad]);
    end
  endtask

  task automatic make_frame(input logic [7:0] seed, input logic [15:0] et, input logic [7:0] b14);
    for (int i = 0; i < N; i++) begin
      stim[i] = seed + 8'(i);
    end
    stim[12] = et[15:8];
    stim[13] = et[7:0];
    stim[14] = b14;
  endtask

  task automatic expect_load(input logic swap);
    for (int i = 0; i < N; i++) begin
      exp_frame[i] = stim[i];
    end
    if (swap) begin
      for (int i = 0; i < 6; i++) begin
        exp_frame[i]     = stim[i + 6];
        exp_frame[i + 6] = stim[i];
      end
    end
  endtask

  task automatic expect_zero();
    for (int i = 0; i < N; i++) begin
      exp_frame[i] = 8'h00;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //             seed   etype     b14    en    swap  ecpri
    vecs[0]  = '{8'h20, 16'hAEFE, 8'h10, 1'b1, 1'b1, 1'b1}; // first frame after reset
    vecs[1]  = '{8'h30, 16'h0800, 8'h45, 1'b1, 1'b0, 1'b0}; // IPv4, pass-through
    vecs[2]  = '{8'h40, 16'hAEFE, 8'h20, 1'b1, 1'b0, 1'b0}; // wrong revision
    vecs[3]  = '{8'h50, 16'hAEFE, 8'h1F, 1'b1, 1'b1, 1'b1}; // low nibble ignored
    vecs[4]  = '{8'h60, 16'hAEFE, 8'h00, 1'b1, 1'b0, 1'b0}; // revision 0
    vecs[5]  = '{8'h70, 16'hFEAE, 8'h10, 1'b1, 1'b0, 1'b0}; // byte-swapped EtherType
    vecs[6]  = '{8'h80, 16'hAEFF, 8'h10, 1'b1, 1'b0, 1'b0}; // low byte off by one
    vecs[7]  = '{8'h90, 16'hAEFE, 8'h10, 1'b1, 1'b1, 1'b1}; // eCPRI again
    vecs[8]  = '{8'hA0, 16'h0800, 8'h10, 1'b0, 1'b0, 1'b1}; // idle: hold vec7
    vecs[9]  = '{8'hB0, 16'hAEFE, 8'h10, 1'b0, 1'b0, 1'b1}; // idle: still hold
    vecs[10] = '{8'hC0, 16'h0800, 8'h11, 1'b1, 1'b0, 1'b0}; // resume
    vecs[11] = '{8'hD0, 16'hBEFE, 8'h10, 1'b1, 1'b0, 1'b0}; // high byte mismatch

    // Reset with a valid eCPRI frame present: the frame must be discarded.
    loopback = 1'b0;
    rst      = 1'b1;
    inp_en   = 1'b1;
    make_frame(8'h01, ET, 8'h10);
    expect_zero();
    for (int c = 0; c < 2; c++) begin
      tick();
      check_frame("reset out");
      check("reset out_en", 32'(out_en), 32'd0);
      check("reset out_ecpri", 32'(out_ecpri), 32'd0);
    end
    rst = 1'b0;

    // Table: back-to-back frames, classification boundaries, idle hold.
    for (int k = 0; k < 12; k++) begin
      make_frame(vecs[k].seed, vecs[k].et, vecs[k].b14);
      inp_en = vecs[k].en;
      if (vecs[k].en) expect_load(vecs[k].swap);
      tick();
      check_frame($sformatf("vec%0d out", k));
      check($sformatf("vec%0d out_en", k), 32'(out_en), 32'(vecs[k].en));
      check($sformatf("vec%0d out_ecpri", k), 32'(out_ecpri), 32'(vecs[k].exp_ecpri));
    end

    // Reference eCPRI frame with explicit MAC values.
    for (int i = 0; i < N; i++) stim[i] = 8'(i);
    for (int i = 0; i < 6; i++) begin
      stim[i]     = 8'hFF;
      stim[i + 6] = 8'(8'h11 * i);
    end
    stim[12] = 8'hAE;
    stim[13] = 8'hFE;
    stim[14] = 8'h10;
    for (int i = 0; i < N; i++) exp_frame[i] = 8'(i);
    exp_frame[0]  = 8'h00; exp_frame[1]  = 8'h11; exp_frame[2]  = 8'h22;
    exp_frame[3]  = 8'h33; exp_frame[4]  = 8'h44; exp_frame[5]  = 8'h55;
    for (int i = 6; i < 12; i++) exp_frame[i] = 8'hFF;
    exp_frame[12] = 8'hAE;
    exp_frame[13] = 8'hFE;
    exp_frame[14] = 8'h10;
    inp_en = 1'b1;
    tick();
    check_frame("ref ecpri out");
    check("ref ecpri out_en", 32'(out_en), 32'd1);
    check("ref ecpri out_ecpri", 32'(out_ecpri), 32'd1);

    // Loopback: load once, hold with out fed back, then pulse to swap back.
    make_frame(8'h05, ET, 8'h10);
    expect_load(1'b1);
    tick();
    check_frame("loop load");
    loopback = 1'b1;
    inp_en   = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_frame("loop hold");
      check("loop hold out_en", 32'(out_en), 32'd0);
      check("loop hold out_ecpri", 32'(out_ecpri), 32'd1);
    end
    inp_en = 1'b1;
    expect_load(1'b0);  // swapping twice restores the original frame in stim
    tick();
    check_frame("loop swap back");
    check("loop swap back out_en", 32'(out_en), 32'd1);
    inp_en   = 1'b0;
    loopback = 1'b0;
    tick();
    check("loop idle out_en", 32'(out_en), 32'd0);

    // Mid-stream reset: the frame present at the reset edge is dropped.
    make_frame(8'h77, ET, 8'h10);
    inp_en = 1'b1;
    rst    = 1'b1;
    expect_zero();
    tick();
    check_frame("midrst out");
    check("midrst out_en", 32'(out_en), 32'd0);
    check("midrst out_ecpri", 32'(out_ecpri), 32'd0);
`ifdef DUMMY_STATS_EN
    check("midrst pkt_cnt", pkt_cnt, 32'd0);
    check("midrst ecpri_cnt", ecpri_cnt, 32'd0);
`endif
    rst    = 1'b0;
    inp_en = 1'b0;
    tick();
    check("post rst out_en", 32'(out_en), 32'd0);

`ifdef DUMMY_STATS_EN
    // Three eCPRI and two other frames back-to-back.
    inp_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      make_frame(8'(k * 16), (k < 3) ? ET : 16'h0800, 8'h10);
      tick();
    end
    inp_en = 1'b0;
    tick();
    check("stats pkt_cnt", pkt_cnt, 32'd5);
    check("stats ecpri_cnt", ecpri_cnt, 32'd3);

    // Wrap of the frame counter.
    force dut.pkt_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.pkt_cnt_q;
    make_frame(8'h42, 16'h0800, 8'h10);
    inp_en = 1'b1;
    tick();
    inp_en = 1'b0;
    check("wrap pkt_cnt", pkt_cnt, 32'd0);
    check("wrap ecpri_cnt", ecpri_cnt, 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
